// File: rtl/id_reg_file_pkg.sv
// Shared constants and types for the ID-stage register file and its
// pending-write scoreboard.
package id_reg_file_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  function automatic logic is_live(input reg_addr_t addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/id_reg_file_if.sv
// Bundle of ID read ports, write-back port, issue port and hazard outputs.
// The pipeline drives through master; the register file sits on slave.
interface id_reg_file_if #(
  parameter int XLEN = id_reg_file_pkg::XLEN
);
  import id_reg_file_pkg::*;

  reg_addr_t       rs1_addr_in;
  reg_addr_t       rs2_addr_in;
  logic            rs1_used_in;
  logic            rs2_used_in;
  logic [XLEN-1:0] rs1_data_out;
  logic [XLEN-1:0] rs2_data_out;
  logic [XLEN-1:0] wb_write_data_in;
  reg_addr_t       wb_rd_addr_in;
  logic            wb_reg_write_en_in;
  logic            issue_valid_in;
  reg_addr_t       issue_rd_in;
  logic            issue_reg_write_in;
  logic            stall_out;
  logic            sb_error_out;

  modport master (
    output rs1_addr_in, rs2_addr_in, rs1_used_in, rs2_used_in,
           wb_write_data_in, wb_rd_addr_in, wb_reg_write_en_in,
           issue_valid_in, issue_rd_in, issue_reg_write_in,
    input  rs1_data_out, rs2_data_out, stall_out, sb_error_out
  );

  modport slave (
    input  rs1_addr_in, rs2_addr_in, rs1_used_in, rs2_used_in,
           wb_write_data_in, wb_rd_addr_in, wb_reg_write_en_in,
           issue_valid_in, issue_rd_in, issue_reg_write_in,
    output rs1_data_out, rs2_data_out, stall_out, sb_error_out
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with RAW / counter-full stall and a
// sticky error for write-backs that were never issued.
module reg_scoreboard
  import id_reg_file_pkg::*;
#(
  parameter int CNT_W = id_reg_file_pkg::CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      rs1_used,
  input  logic      rs2_used,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      issue_reg_write,
  input  logic      wb_en,
  input  reg_addr_t wb_rd,
  output logic      stall,
  output logic      sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count [32];
  logic             wb_fire;
  logic             issue_fire;
  logic             raw1;
  logic             raw2;
  logic             full;
  logic [31:1]      inc_hit;
  logic [31:1]      dec_hit;

  // A write-back landing this cycle retires one pending write before the
  // hazard check, so pending != 0 means the count exceeds that one retire.
  always_comb begin
    wb_fire    = wb_en && is_live(wb_rd);
    raw1       = 1'b0;
    raw2       = 1'b0;
    full       = 1'b0;
    if (rs1_used && is_live(rs1_addr))
      raw1 = (wb_fire && wb_rd == rs1_addr) ? (count[rs1_addr] > CNT_W'(1))
                                            : (count[rs1_addr] != '0);
    if (rs2_used && is_live(rs2_addr))
      raw2 = (wb_fire && wb_rd == rs2_addr) ? (count[rs2_addr] > CNT_W'(1))
                                            : (count[rs2_addr] != '0);
    if (issue_valid && issue_reg_write && is_live(issue_rd))
      full = (count[issue_rd] == CNT_MAX) && !(wb_fire && wb_rd == issue_rd);
    stall      = rst && (raw1 || raw2 || full);
    issue_fire = issue_valid && !stall && issue_reg_write && is_live(issue_rd);
    inc_hit    = '0;
    dec_hit    = '0;
    for (int r = 1; r < 32; r++) begin
      inc_hit[r] = issue_fire && issue_rd == reg_addr_t'(r);
      dec_hit[r] = wb_fire && wb_rd == reg_addr_t'(r);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) count[r] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_hit[r] && !dec_hit[r])
          count[r] <= count[r] + CNT_W'(1);
        else if (dec_hit[r] && !inc_hit[r] && count[r] != '0)
          count[r] <= count[r] - CNT_W'(1);
      end
      if (wb_fire && count[wb_rd] == '0)
        sb_error <= 1'b1;
    end
  end

endmodule

// File: rtl/id_reg_file.sv
// ID-stage register file: x0 hard-wired to zero, same-cycle write-back
// bypass on both read ports, and a scoreboard that stalls on pending writes.
module id_reg_file
  import id_reg_file_pkg::*;
#(
  parameter int XLEN  = id_reg_file_pkg::XLEN,
  parameter int CNT_W = id_reg_file_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  id_reg_file_if.slave bus
);

  logic [XLEN-1:0] regs [32];
  logic            wb_fire;

  assign wb_fire = bus.wb_reg_write_en_in && is_live(bus.wb_rd_addr_in);

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_fire) begin
      regs[bus.wb_rd_addr_in] <= bus.wb_write_data_in;
    end
  end

  always_comb begin
    bus.rs1_data_out = '0;
    bus.rs2_data_out = '0;
    if (rst && is_live(bus.rs1_addr_in))
      bus.rs1_data_out = (wb_fire && bus.wb_rd_addr_in == bus.rs1_addr_in)
                         ? bus.wb_write_data_in : regs[bus.rs1_addr_in];
    if (rst && is_live(bus.rs2_addr_in))
      bus.rs2_data_out = (wb_fire && bus.wb_rd_addr_in == bus.rs2_addr_in)
                         ? bus.wb_write_data_in : regs[bus.rs2_addr_in];
  end

  reg_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .rs1_addr        (bus.rs1_addr_in),
    .rs2_addr        (bus.rs2_addr_in),
    .rs1_used        (bus.rs1_used_in),
    .rs2_used        (bus.rs2_used_in),
    .issue_valid     (bus.issue_valid_in),
    .issue_rd        (bus.issue_rd_in),
    .issue_reg_write (bus.issue_reg_write_in),
    .wb_en           (bus.wb_reg_write_en_in),
    .wb_rd           (bus.wb_rd_addr_in),
    .stall           (bus.stall_out),
    .sb_error        (bus.sb_error_out)
  );

endmodule

// File: tb/tb_id_reg_file.sv
// Bench for id_reg_file: directed scenarios plus randomized traffic checked
// against an array/counter reference model of the register file semantics.
module tb_id_reg_file;
  import id_reg_file_pkg::*;

  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  id_reg_file_if #(.XLEN(XLEN)) bus();

  id_reg_file #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [XLEN-1:0] model_regs [32];
  int              model_cnt  [32];
  bit              model_err;
  int              total = 0;
  int              bad   = 0;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit wbHits(input logic [4:0] a);
    return bus.wb_reg_write_en_in && a != 5'd0 && bus.wb_rd_addr_in == a;
  endfunction

  function automatic logic [XLEN-1:0] expData(input logic [4:0] a);
    if (!rst || a == 5'd0) return '0;
    if (wbHits(a)) return bus.wb_write_data_in;
    return model_regs[a];
  endfunction

  function automatic int pendingOf(input logic [4:0] a);
    if (wbHits(a)) return (model_cnt[a] > 0) ? model_cnt[a] - 1 : 0;
    return model_cnt[a];
  endfunction

  function automatic bit expStall();
    if (!rst) return 1'b0;
    if (bus.rs1_used_in && bus.rs1_addr_in != 5'd0 && pendingOf(bus.rs1_addr_in) != 0) return 1'b1;
    if (bus.rs2_used_in && bus.rs2_addr_in != 5'd0 && pendingOf(bus.rs2_addr_in) != 0) return 1'b1;
    if (bus.issue_valid_in && bus.issue_reg_write_in && bus.issue_rd_in != 5'd0 &&
        model_cnt[bus.issue_rd_in] == CMAX && !wbHits(bus.issue_rd_in)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
      model_cnt[i]  = 0;
    end
    model_err = 1'b0;
  endtask

  // Applies the rising edge to the model using the stall seen before it.
  task automatic modelClock(input bit stalled);
    bit issue_fire;
    bit wb_fire;
    if (!rst) return;
    issue_fire = bus.issue_valid_in && !stalled && bus.issue_reg_write_in && bus.issue_rd_in != 5'd0;
    wb_fire    = bus.wb_reg_write_en_in && bus.wb_rd_addr_in != 5'd0;
    if (wb_fire) begin
      if (model_cnt[bus.wb_rd_addr_in] == 0) model_err = 1'b1;
      model_regs[bus.wb_rd_addr_in] = bus.wb_write_data_in;
    end
    if (!(issue_fire && wb_fire && bus.issue_rd_in == bus.wb_rd_addr_in)) begin
      if (issue_fire) model_cnt[bus.issue_rd_in]++;
      if (wb_fire && model_cnt[bus.wb_rd_addr_in] > 0) model_cnt[bus.wb_rd_addr_in]--;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rs1"},   bus.rs1_data_out, expData(bus.rs1_addr_in));
    checkOutput({tag, ".rs2"},   bus.rs2_data_out, expData(bus.rs2_addr_in));
    checkOutput({tag, ".stall"}, XLEN'(bus.stall_out), XLEN'(expStall()));
    checkOutput({tag, ".err"},   XLEN'(bus.sb_error_out), XLEN'(model_err));
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2,
                               input bit u1, input bit u2,
                               input bit iv, input logic [4:0] ird, input bit irw,
                               input bit we, input logic [4:0] wrd,
                               input logic [XLEN-1:0] wd);
    bus.rs1_addr_in        = r1;
    bus.rs2_addr_in        = r2;
    bus.rs1_used_in        = u1;
    bus.rs2_used_in        = u2;
    bus.issue_valid_in     = iv;
    bus.issue_rd_in        = ird;
    bus.issue_reg_write_in = irw;
    bus.wb_reg_write_en_in = we;
    bus.wb_rd_addr_in      = wrd;
    bus.wb_write_data_in   = wd;
  endtask

  // Called just after a falling edge; checks, clocks, returns at next fall.
  task automatic runCycle(input string tag);
    bit stalled;
    #1;
    checkAll(tag);
    stalled = expStall();
    @(posedge clk);
    modelClock(stalled);
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    #3 rst = 1'b0;
    modelReset();
    #1 checkAll(tag);
    @(negedge clk);
    #1 checkAll({tag, "_hold"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int pick;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < 32; a++) begin
      applyStimulus(a[4:0], 5'(31 - a), 1, 1, 0, 0, 0, 0, 0, '0);
      runCycle($sformatf("zero%0d", a));
    end

    applyStimulus(5, 0, 1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    #1 checkOutput("byp5_lit", bus.rs1_data_out, 32'hDEADBEEF);
    runCycle("byp5");
    applyStimulus(5, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    #1 checkOutput("stor5_lit", bus.rs1_data_out, 32'hDEADBEEF);
    runCycle("stor5");

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h12345678);
    runCycle("x0w");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, '0);
    runCycle("x0r");

    doReset("rstA");

    applyStimulus(0, 0, 0, 0, 1, 7, 1, 0, 0, '0);
    runCycle("iss7");
    applyStimulus(7, 0, 1, 0, 0, 0, 0, 0, 0, '0);
    #1 checkOutput("raw7_lit", XLEN'(bus.stall_out), 1);
    runCycle("raw7");
    applyStimulus(7, 0, 1, 0, 0, 0, 0, 1, 7, 32'h55);
    #1 checkOutput("wb7_lit", XLEN'(bus.stall_out), 0);
    runCycle("wb7");

    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 9, 1, 0, 0, '0);
      runCycle($sformatf("iss9_%0d", k));
    end
    applyStimulus(0, 0, 0, 0, 1, 9, 1, 0, 0, '0);
    #1 checkOutput("full9_lit", XLEN'(bus.stall_out), 1);
    runCycle("full9");
    applyStimulus(9, 0, 0, 0, 1, 9, 1, 1, 9, 32'h99);
    #1 checkOutput("full9wb_lit", XLEN'(bus.stall_out), 0);
    runCycle("full9wb");
    applyStimulus(0, 0, 0, 0, 1, 9, 1, 0, 0, '0);
    #1 checkOutput("still3_lit", XLEN'(bus.stall_out), 1);
    runCycle("still3");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(9, 0, 1, 0, 0, 0, 0, 1, 9, 32'(k + 16'hA0));
      runCycle($sformatf("drain9_%0d", k));
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33);
    runCycle("err3");
    applyStimulus(9, 3, 1, 1, 0, 0, 0, 0, 0, '0);
    #1 checkOutput("errsticky_lit", XLEN'(bus.sb_error_out), 1);
    runCycle("errsticky");
    #3 rst = 1'b0;
    modelReset();
    #1 checkOutput("async_err", XLEN'(bus.sb_error_out), 0);
    checkOutput("async_rs1", bus.rs1_data_out, '0);
    checkAll("async");
    @(negedge clk);
    rst = 1'b1;
    runCycle("postrst");

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset("rstR");
      end else begin
        pick = 0;
        if ($urandom_range(0, 9) < 7) begin
          for (int k = 0; k < 8; k++) begin
            int c;
            c = $urandom_range(1, 7);
            if (model_cnt[c] > 0) begin
              pick = c;
              break;
            end
          end
        end
        applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom),
                      1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      pick != 0, 5'(pick), $urandom);
        if ($urandom_range(0, 19) == 0) begin
          bus.wb_reg_write_en_in = 1'b1;
          bus.wb_rd_addr_in      = 5'($urandom_range(0, 7));
        end
        runCycle("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
